// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, control codes, token match and data decode.
// The encode side imports this same package so the tokens live in one place.
package tmds_pkg;

    // Control tokens, MSB written first; bit 0 is the first bit on the wire.
    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        CtrlC00 = 2'b00,
        CtrlC01 = 2'b01,
        CtrlC10 = 2'b10,
        CtrlC11 = 2'b11
    } ctrl_code_e;

    typedef enum logic {
        StSearch = 1'b0,
        StLocked = 1'b1
    } align_state_e;

    function automatic logic is_token(input logic [9:0] w);
        return (w == TOKEN_C00) || (w == TOKEN_C01) || (w == TOKEN_C10) || (w == TOKEN_C11);
    endfunction

    // Only meaningful when is_token(w) is true.
    function automatic ctrl_code_e token_code(input logic [9:0] w);
        ctrl_code_e c;
        case (w)
            TOKEN_C01: c = CtrlC01;
            TOKEN_C10: c = CtrlC10;
            TOKEN_C11: c = CtrlC11;
            default:   c = CtrlC00;
        endcase
        return c;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects XOR).
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

endpackage

// File: rtl/tmds_rx_channel_if.sv
// Raw-word input and decoded-output bundle of one TMDS receive channel.
interface tmds_rx_channel_if;
    logic [9:0] in_raw;
    logic [7:0] out_data;
    logic       out_de;
    logic [1:0] out_c;
    logic       out_locked;
    logic [3:0] out_offset;

    // master: deserializer side feeding words and consuming the decode.
    modport master (
        output in_raw,
        input  out_data,
        input  out_de,
        input  out_c,
        input  out_locked,
        input  out_offset
    );

    // slave: the receive channel itself.
    modport slave (
        input  in_raw,
        output out_data,
        output out_de,
        output out_c,
        output out_locked,
        output out_offset
    );
endinterface

// File: rtl/tmds_word_aligner.sv
// Word aligner: history register, bit-slip window mux and the run/timer lock FSM
// that hunts for the offset at which control tokens repeat.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int unsigned MIN_RUN = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [9:0] raw_i,
    output logic [9:0] aligned_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MIN_RUN + 1);

    logic [9:0]   raw_prev_q, raw_prev_d;
    logic [9:0]   aligned_q, aligned_d;
    logic [RW-1:0] run_q, run_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]   offset_q, offset_d;
    logic         settle_q, settle_d;
    logic         locked_q, locked_d;
    align_state_e state_q, state_d;

    logic [19:0] cat;
    logic        token_s1;
    logic        run_hit;
    logic        timeout;

    assign cat = {raw_i, raw_prev_q};

    // Next-state: window select, run counting, and lock/offset decisions.
    always_comb begin
        raw_prev_d = raw_i;
        aligned_d  = cat[offset_q +: 10];

        // The word latched across an offset change mixes two offsets; never count it.
        token_s1 = is_token(aligned_q) && !settle_q;
        run_hit  = token_s1 && (run_q == RW'(MIN_RUN - 1));
        timeout  = (timer_q == TW'(TIMEOUT - 1));

        state_d  = state_q;
        offset_d = offset_q;
        settle_d = 1'b0;
        timer_d  = timer_q + 1'b1;

        if (!token_s1) begin
            run_d = '0;
        end else if (run_q != RW'(MIN_RUN)) begin
            run_d = run_q + 1'b1;
        end else begin
            run_d = run_q;
        end

        // Same rules in both states: a run takes or refreshes lock, a timeout drops
        // to search and slips one bit. A run in the timeout cycle wins.
        if (run_hit) begin
            state_d = StLocked;
            timer_d = '0;
        end else if (timeout) begin
            state_d  = StSearch;
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            timer_d  = '0;
            run_d    = '0;
            settle_d = 1'b1;
        end

        locked_d = (state_d == StLocked);
    end

    // State registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (reset) begin
            raw_prev_q <= '0;
            aligned_q  <= '0;
            run_q      <= '0;
            timer_q    <= '0;
            offset_q   <= '0;
            settle_q   <= 1'b0;
            locked_q   <= 1'b0;
            state_q    <= StSearch;
        end else begin
            raw_prev_q <= raw_prev_d;
            aligned_q  <= aligned_d;
            run_q      <= run_d;
            timer_q    <= timer_d;
            offset_q   <= offset_d;
            settle_q   <= settle_d;
            locked_q   <= locked_d;
            state_q    <= state_d;
        end
    end

    assign aligned_o = aligned_q;
    assign locked_o  = locked_q;
    assign offset_o  = offset_q;

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: word alignment followed by a registered decode stage
// producing video data or control codes.
module tmds_rx_channel
    import tmds_pkg::*;
#(
    parameter int unsigned MIN_RUN = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              pclk,
    input  logic              reset,
    tmds_rx_channel_if.slave  bus
);

    logic [9:0] aligned;
    logic       locked;
    logic [3:0] offset;

    logic [7:0] data_q, data_d;
    logic       de_q, de_d;
    ctrl_code_e c_q, c_d;

    tmds_word_aligner #(
        .MIN_RUN (MIN_RUN),
        .TIMEOUT (TIMEOUT)
    ) u_aligner (
        .pclk      (pclk),
        .reset     (reset),
        .raw_i     (bus.in_raw),
        .aligned_o (aligned),
        .locked_o  (locked),
        .offset_o  (offset)
    );

    // Decode stage: outputs stay quiet until aligned; control code holds through video.
    always_comb begin
        data_d = '0;
        de_d   = 1'b0;
        c_d    = c_q;
        if (!locked) begin
            c_d = CtrlC00;
        end else if (is_token(aligned)) begin
            c_d = token_code(aligned);
        end else begin
            de_d   = 1'b1;
            data_d = tmds_decode(aligned);
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (reset) begin
            data_q <= '0;
            de_q   <= 1'b0;
            c_q    <= CtrlC00;
        end else begin
            data_q <= data_d;
            de_q   <= de_d;
            c_q    <= c_d;
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_de     = de_q;
    assign bus.out_c      = c_q;
    assign bus.out_locked = locked;
    assign bus.out_offset = offset;

endmodule

// File: doc/tmds_rx_channel.md
Name: tmds_rx_channel

Overview:
- Receive-side counterpart of the TMDS transmit path: one instance per TMDS channel (red, green, blue).
- Takes 10-bit raw words already deserialized, one per pclk, LSB = first bit on the wire.
- Finds the 10-bit word boundary by hunting for runs of control tokens, then TMDS-decodes each word back to 8-bit video data or the 2-bit control code.
- Sits between an external deserializer/IO primitive and the video timing recovery logic.

Parameters:
- MIN_RUN, 8: number of consecutive identical-offset control tokens required to declare or refresh lock (range 2..255).
- TIMEOUT, 4096: pclk cycles without a qualifying control run before lock is dropped or the search offset advances; must exceed one full line period.
- TW, $clog2(TIMEOUT+1): width of the timeout counter (localparam).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_raw  in  10  raw deserialized word, bit 0 earliest on wire
- out_data  out  8  decoded video byte
- out_de  out  1  1 = out_data valid video, 0 = control period
- out_c  out  2  decoded control code {c1,c0}; valid when out_de=0 and out_locked=1
- out_locked  out  1  word alignment established
- out_offset  out  4  current bit-slip offset 0..9

Behaviour:
- One clock (pclk); reset is synchronous and active-high.
- Reset: all outputs 0, state SEARCH, offset 0, all counters 0, raw history register 0.
- Alignment window:
  - raw_prev <= in_raw each cycle; cat = {in_raw, raw_prev} (20 bits).
  - aligned = cat[offset+9 : offset], registered as stage 1.
- Control tokens (aligned[9:0], MSB written first):
  - 10'b1101010100 -> c=00
  - 10'b0010101011 -> c=01
  - 10'b0101010100 -> c=10
  - 10'b1010101011 -> c=11
- Data decode, stage 2:
  - d = aligned[9] ? ~aligned[7:0] : aligned[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = d[i] ^ d[i-1] if aligned[8] = 1, else ~(d[i] ^ d[i-1]).
- Latency: in_raw sampled at edge N is reflected on outputs after edge N+2 (word completing the window at offset k follows the same rule).
- Outputs while not locked: out_de = 0, out_data = 0, out_c = 00; out_offset is always live.
- Outputs while locked:
  - Control token: out_de = 0, out_c = code, out_data = 0.
  - Otherwise: out_de = 1, out_data = decoded byte, out_c holds its last value.
- Run counter:
  - Increments on each stage-1 control token; clears on a non-token or an offset change.
  - Saturates at MIN_RUN; "run_hit" pulses once, in the cycle the counter reaches MIN_RUN.
- State machine:
  - SEARCH:
    - run_hit -> LOCKED (out_locked = 1 from the next cycle); timer cleared.
    - Timer reaching TIMEOUT -> offset <= (offset == 9) ? 0 : offset + 1; timer and run counter clear; stay in SEARCH.
  - LOCKED:
    - run_hit clears the timer.
    - Timer reaching TIMEOUT -> SEARCH, out_locked = 0 next cycle, offset advances as above.
- Simultaneous run_hit and timeout in the same cycle: run_hit wins; no offset change, lock taken or kept.
- Offset change: stage-1 word in the following cycle is treated as not-a-token (settling cycle), so a run cannot straddle two offsets.
- Reset asserted mid-lock: next cycle is identical to the post-reset state.

Decomposition:
- Shared package tmds_pkg: the four control-token constants, the control-code enum, and a decode function (10-bit to 8-bit).
- The encode side uses the same package, keeping tokens defined in one place.
- Natural sub-module: tmds_word_aligner (history register, window mux, run/timer FSM, offset). tmds_rx_channel instantiates it and adds the decode stage.

Test Plan:
- Reset then 20 cycles of in_raw = 10'h354 (token c=00) at offset 0 -> out_locked = 1 after the 8th token + 2 cycles; out_offset = 0; out_c = 00; out_de = 0.
- Locked, feed 10'h100 then 10'h200 -> out_data = 8'h00 then 8'hFF, out_de = 1, each 2 cycles after input.
- Stream of token 10'h0AB (c=01) rotated by 3 bits, TIMEOUT = 16 -> offset steps 0, 1, 2, 3 at 16-cycle intervals, then locks with out_offset = 3 and out_c = 01.
- Locked, then TIMEOUT cycles of data words only -> out_locked falls to 0; out_offset increments by 1 (9 wraps to 0).
- Control run completing in the same cycle the timer hits TIMEOUT -> stays LOCKED, offset unchanged.
- Reset pulse while locked mid-stream -> next cycle all outputs 0 and offset 0; relock requires a fresh MIN_RUN run.
